// File: rtl/sap_sequencer.sv
// rtl/sap_sequencer.sv - SAP instruction sequencer: falling-edge Moore FSM driving the datapath control word
module sap_sequencer #(
   parameter int OPW = 4,
   parameter int CW  = 16
) (
   input  logic           CLK,
   input  logic           CLR,
   input  logic [OPW-1:0] opcode,
   input  logic           ZF,
   input  logic           CF,
   input  logic           RUN,
   input  logic           STEP,
   output logic [CW-1:0]  con,
   output logic           lp,
   output logic [2:0]     tstate,
   output logic           fetch,
   output logic           halted,
   output logic           bad_op,
   output logic           jmp_taken
);

   typedef enum logic [3:0] {
      S_S0, S_T1, S_T2, S_T3,
      S_L1, S_L2,
      S_A1, S_A2, S_A3,
      S_W1, S_W2, S_W3,
      S_JUMP, S_O1, S_HALT
   } state_t;

   state_t           r_state;
   state_t           w_next;
   state_t           w_dec_state;
   logic             r_step_q;
   logic             r_bad_op;
   logic [1:0]       r_alu_sel;
   logic             w_adv;
   logic             w_dec_bad;
   logic             w_op_hi;
   logic [OPW-1:0]   w_op_hi_bits;
   logic [15:0]      w_con16;

   // Anything with bits set above bit 3 is outside the defined opcode range.
   assign w_op_hi_bits = opcode >> 4;
   assign w_op_hi      = |w_op_hi_bits;

   assign w_adv = RUN | (STEP & ~r_step_q);

   always_comb begin
      w_dec_state = S_T1;
      w_dec_bad   = 1'b0;
      if (w_op_hi) begin
         w_dec_bad = 1'b1;
      end else begin
         case (opcode[3:0])
            4'd0:                  w_dec_state = S_L1;
            4'd1, 4'd2, 4'd3, 4'd4: w_dec_state = S_A1;
            4'd5:                  w_dec_state = S_W1;
            4'd6:                  w_dec_state = S_JUMP;
            4'd7:                  w_dec_state = ZF  ? S_JUMP : S_T1;
            4'd8:                  w_dec_state = CF  ? S_JUMP : S_T1;
            4'd9:                  w_dec_state = !ZF ? S_JUMP : S_T1;
            4'd14:                 w_dec_state = S_O1;
            4'd15:                 w_dec_state = S_HALT;
            default:               w_dec_bad   = 1'b1;
         endcase
      end
   end

   always_ff @(negedge CLK) begin
      if (CLR) begin
         r_state <= S_S0;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(negedge CLK) begin
      if (CLR) begin
         r_step_q  <= 1'b0;
         r_bad_op  <= 1'b0;
         r_alu_sel <= 2'd0;
      end else begin
         r_step_q <= STEP;
         if (w_adv && r_state == S_T3) begin
            r_bad_op  <= r_bad_op | w_dec_bad;
            r_alu_sel <= opcode[1:0] - 2'd1;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      if (w_adv) begin
         case (r_state)
            S_S0:    w_next = S_T1;
            S_T1:    w_next = S_T2;
            S_T2:    w_next = S_T3;
            S_T3:    w_next = w_dec_state;
            S_L1:    w_next = S_L2;
            S_A1:    w_next = S_A2;
            S_A2:    w_next = S_A3;
            S_W1:    w_next = S_W2;
            S_W2:    w_next = S_W3;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_T1;
         endcase
      end
   end

   always_comb begin
      w_con16   = 16'h3E07;
      tstate    = 3'd0;
      lp        = 1'b0;
      halted    = 1'b0;
      case (r_state)
         S_S0:   begin w_con16 = 16'h3E07; tstate = 3'd0; end
         S_T1:   begin w_con16 = 16'h5E07; tstate = 3'd1; end
         S_T2:   begin w_con16 = 16'hBE07; tstate = 3'd2; end
         S_T3:   begin w_con16 = 16'h2607; tstate = 3'd3; end
         S_L1:   begin w_con16 = 16'h1A07; tstate = 3'd4; end
         S_L2:   begin w_con16 = 16'h2C07; tstate = 3'd5; end
         S_A1:   begin w_con16 = 16'h1A07; tstate = 3'd4; end
         S_A2:   begin w_con16 = 16'h2E03; tstate = 3'd5; end
         S_A3:   begin w_con16 = 16'h3C0F | {10'd0, r_alu_sel, 4'd0}; tstate = 3'd6; end
         S_W1:   begin w_con16 = 16'h3F05; tstate = 3'd4; end
         S_W2:   begin w_con16 = 16'h3C87; tstate = 3'd5; end
         S_W3:   begin w_con16 = 16'h3E43; tstate = 3'd6; end
         S_JUMP: begin w_con16 = 16'h3A07; tstate = 3'd4; lp = 1'b1; end
         S_O1:   begin w_con16 = 16'h3F06; tstate = 3'd4; end
         S_HALT: begin w_con16 = 16'h3E07; tstate = 3'd4; halted = 1'b1; end
         default: begin w_con16 = 16'h3E07; tstate = 3'd0; end
      endcase
   end

   assign con       = CW'(w_con16);
   assign fetch     = (r_state == S_T1) || (r_state == S_T2) || (r_state == S_T3);
   assign jmp_taken = lp;
   assign bad_op    = r_bad_op;

endmodule

// File: tb/tb_sap_sequencer.sv
// tb/tb_sap_sequencer.sv - randomized and directed checks of sap_sequencer against an instruction-level model
module tb_sap_sequencer;

   logic        CLK;
   logic        CLR;
   logic [3:0]  opcode;
   logic        ZF, CF, RUN, STEP;
   logic [15:0] con;
   logic        lp, fetch, halted, bad_op, jmp_taken;
   logic [2:0]  tstate;

   int n_tests = 0;
   int n_fail  = 0;

   sap_sequencer #(.OPW(4), .CW(16)) dut (
      .CLK(CLK), .CLR(CLR), .opcode(opcode), .ZF(ZF), .CF(CF),
      .RUN(RUN), .STEP(STEP), .con(con), .lp(lp), .tstate(tstate),
      .fetch(fetch), .halted(halted), .bad_op(bad_op), .jmp_taken(jmp_taken)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: each instruction is a list of cycles (control word, T-state, flags).
   typedef struct packed {
      logic [15:0] con;
      logic [2:0]  ts;
      logic        lp;
      logic        hlt;
      logic        t3;
   } ent_t;

   ent_t m_cur;
   ent_t m_q[$];
   bit   m_bad;
   bit   m_prev;
   bit   m_valid = 1'b0;

   function automatic ent_t mk(logic [15:0] c, logic [2:0] t, logic l, logic h, logic t3);
      ent_t e;
      e.con = c; e.ts = t; e.lp = l; e.hlt = h; e.t3 = t3;
      return e;
   endfunction

   function automatic void m_decode(int op, bit zf, bit cf);
      bit jmp;
      jmp = (op == 6) || (op == 7 && zf) || (op == 8 && cf) || (op == 9 && !zf);
      if (op == 0) begin
         m_q.push_back(mk(16'h1A07, 4, 0, 0, 0));
         m_q.push_back(mk(16'h2C07, 5, 0, 0, 0));
      end else if (op >= 1 && op <= 4) begin
         m_q.push_back(mk(16'h1A07, 4, 0, 0, 0));
         m_q.push_back(mk(16'h2E03, 5, 0, 0, 0));
         m_q.push_back(mk(16'h3C0F + 16'((op - 1) * 16), 6, 0, 0, 0));
      end else if (op == 5) begin
         m_q.push_back(mk(16'h3F05, 4, 0, 0, 0));
         m_q.push_back(mk(16'h3C87, 5, 0, 0, 0));
         m_q.push_back(mk(16'h3E43, 6, 0, 0, 0));
      end else if (op >= 6 && op <= 9) begin
         if (jmp) m_q.push_back(mk(16'h3A07, 4, 1, 0, 0));
      end else if (op == 14) begin
         m_q.push_back(mk(16'h3F06, 4, 0, 0, 0));
      end else if (op == 15) begin
         m_q.push_back(mk(16'h3E07, 4, 0, 1, 0));
      end else begin
         m_bad = 1'b1;
      end
   endfunction

   function automatic void m_advance(int op, bit zf, bit cf);
      if (m_cur.hlt) return;
      if (m_q.size() == 0) begin
         if (m_cur.t3) m_decode(op, zf, cf);
         if (m_q.size() == 0) begin
            m_q.push_back(mk(16'h5E07, 1, 0, 0, 0));
            m_q.push_back(mk(16'hBE07, 2, 0, 0, 0));
            m_q.push_back(mk(16'h2607, 3, 0, 0, 1));
         end
      end
      m_cur = m_q.pop_front();
   endfunction

   always @(negedge CLK) begin
      if (CLR) begin
         m_cur   = mk(16'h3E07, 0, 0, 0, 0);
         m_q.delete();
         m_bad   = 1'b0;
         m_prev  = 1'b0;
         m_valid = 1'b1;
      end else begin
         if (RUN || (STEP && !m_prev)) m_advance(int'(opcode), ZF, CF);
         m_prev = STEP;
      end
   end

   always @(posedge CLK) begin
      if (m_valid) begin
         logic exp_f;
         exp_f = (m_cur.ts >= 3'd1) && (m_cur.ts <= 3'd3);
         n_tests++;
         if ({con, tstate, lp, fetch, halted, bad_op, jmp_taken} !==
             {m_cur.con, m_cur.ts, m_cur.lp, exp_f, m_cur.hlt, m_bad, m_cur.lp}) begin
            n_fail++;
            $display("FAIL cycle t=%0t: got con=%h ts=%0d lp=%b f=%b h=%b bad=%b j=%b, expected con=%h ts=%0d lp=%b f=%b h=%b bad=%b j=%b",
                     $time, con, tstate, lp, fetch, halted, bad_op, jmp_taken,
                     m_cur.con, m_cur.ts, m_cur.lp, exp_f, m_cur.hlt, m_bad, m_cur.lp);
         end
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   logic [15:0] seq_con [6];
   logic [2:0]  seq_ts  [6];

   initial begin
      CLR = 1'b1; RUN = 1'b1; STEP = 1'b0; opcode = 4'd0; ZF = 1'b0; CF = 1'b0;
      cyc(); cyc();
      chk("reset_con", 32'(con), 32'h3E07);
      chk("reset_flags", {26'd0, tstate, lp, fetch, halted, bad_op, jmp_taken}, 32'd0);
      CLR = 1'b0;

      seq_con = '{16'h5E07, 16'hBE07, 16'h2607, 16'h1A07, 16'h2C07, 16'h5E07};
      seq_ts  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk($sformatf("lda_con%0d", i), 32'(con), 32'(seq_con[i]));
         chk($sformatf("lda_ts%0d", i), 32'(tstate), 32'(seq_ts[i]));
      end

      opcode = 4'd7; ZF = 1'b1;
      cyc(); cyc(); cyc();
      chk("jz_con", 32'(con), 32'h3A07);
      chk("jz_lp_j", {30'd0, lp, jmp_taken}, 32'd3);
      cyc();
      chk("jz_ret", 32'(con), 32'h5E07);
      ZF = 1'b0;
      cyc(); cyc(); cyc();
      chk("jz_nt_con", 32'(con), 32'h5E07);
      chk("jz_nt_lp", 32'(lp), 32'd0);

      opcode = 4'd11;
      cyc(); cyc();
      chk("ill_pre", 32'(bad_op), 32'd0);
      cyc();
      chk("ill_bad", 32'(bad_op), 32'd1);
      chk("ill_ts", 32'(tstate), 32'd1);
      opcode = 4'd1;
      repeat (5) cyc();
      chk("add_a3", 32'(con), 32'h3C0F);
      chk("add_bad", 32'(bad_op), 32'd1);
      CLR = 1'b1;
      cyc();
      chk("clr_bad", 32'(bad_op), 32'd0);
      CLR = 1'b0;

      opcode = 4'd15;
      repeat (4) cyc();
      chk("hlt_h", 32'(halted), 32'd1);
      chk("hlt_ts", 32'(tstate), 32'd4);
      for (int i = 0; i < 20; i++) begin
         opcode = 4'($urandom_range(0, 15));
         RUN = 1'($urandom_range(0, 1));
         STEP = 1'($urandom_range(0, 1));
         ZF = 1'($urandom_range(0, 1));
         cyc();
         chk("hlt_hold", {15'd0, halted, con}, 32'h0001_3E07);
      end
      CLR = 1'b1;
      cyc();
      chk("hlt_clr", {13'd0, tstate, halted, con}, 32'h0000_3E07);
      CLR = 1'b0; RUN = 1'b0; STEP = 1'b0; opcode = 4'd0;

      cyc();
      chk("step_idle", 32'(tstate), 32'd0);
      STEP = 1'b1;
      repeat (10) cyc();
      chk("step_held", 32'(tstate), 32'd1);
      STEP = 1'b0;
      cyc();
      repeat (3) begin
         STEP = 1'b1; cyc();
         STEP = 1'b0; cyc();
      end
      chk("step_3", {13'd0, tstate, con}, 32'h0004_1A07);
      STEP = 1'b1; CLR = 1'b1;
      cyc();
      chk("step_clr", 32'(tstate), 32'd0);
      STEP = 1'b0;
      cyc();
      CLR = 1'b0;
      cyc();
      chk("step_clr_hold", {13'd0, tstate, con}, 32'h0000_3E07);

      RUN = 1'b1; opcode = 4'd2;
      repeat (5) cyc();
      chk("sub_a2", {13'd0, tstate, con}, 32'h0005_2E03);
      CLR = 1'b1;
      cyc();
      chk("sub_clr", {13'd0, tstate, con}, 32'h0000_3E07);
      CLR = 1'b0;
      repeat (6) cyc();
      chk("sub_a3", {13'd0, tstate, con}, 32'h0006_3C1F);

      for (int i = 0; i < 3000; i++) begin
         int op;
         op = $urandom_range(0, 15);
         if (op == 15 && $urandom_range(0, 3) != 0) op = 14;
         opcode = 4'(op);
         ZF   = 1'($urandom_range(0, 1));
         CF   = 1'($urandom_range(0, 1));
         RUN  = ($urandom_range(0, 3) != 0);
         STEP = 1'($urandom_range(0, 1));
         CLR  = ($urandom_range(0, 39) == 0);
         cyc();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Parametrised SAP instruction sequencer that replaces the fixed-opcode controller. It is a Moore state machine, updated on the falling edge of CLK, that drives the control word for each T-state. It adds conditional and unconditional jumps, single-step execution, illegal-opcode detection and T-state and status outputs. It sits between the instruction register and flag register on one side and the datapath control lines on the other.

## Interface
- OPW, 4: opcode width; must be ≥4. Opcode values above 15 are illegal.
- CW, 16: control-word width; must be ≥16. Bits CW-1:16 are always 0.
- CLK  in  1: system clock. All state updates occur on its falling edge.
- CLR  in  1: reset, synchronous, active-high, sampled on the CLK falling edge.
- opcode  in  OPW: current IR opcode field. Sampled only at the end of T3.
- ZF  in  1: zero flag. Sampled only at the end of T3.
- CF  in  1: carry flag. Sampled only at the end of T3.
- RUN  in  1: 1 = free-run; 0 = single-step.
- STEP  in  1: step request, used when RUN=0. Each 0→1 transition advances exactly one state.
- con  out  CW: datapath control word, combinational from state.
- lp  out  1: load PC from bus. High only in the JUMP state.
- tstate  out  3: T-state number (0 = reset state, 1..6).
- fetch  out  1: high in T1, T2 and T3.
- halted  out  1: high in the HALT state.
- bad_op  out  1: sticky illegal-opcode flag.
- jmp_taken  out  1: high in the JUMP state.

## Operation
- States, with con (hex), tstate, and next state:
  - S0: 3E07, tstate 0, next T1.
  - T1: 5E07, tstate 1, next T2.
  - T2: BE07, tstate 2, next T3.
  - T3: 2607, tstate 3, next state decoded from opcode.
- T3 decode:
  - 0 LDA → L1 (1A07) → L2 (2C07) → T1.
  - 1 ADD, 2 SUB, 3 AND, 4 OR → A1 (1A07) → A2 (2E03) → A3 → T1. A3 is 3C0F for ADD, 3C1F for SUB, 3C2F for AND, 3C3F for OR.
  - 5 SWAP → W1 (3F05) → W2 (3C87) → W3 (3E43) → T1.
  - 6 JMP → JUMP (unconditional).
  - 7 JZ → JUMP if ZF=1.
  - 8 JC → JUMP if CF=1.
  - 9 JNZ → JUMP if ZF=0.
  - A branch that is not taken goes directly to T1.
  - JUMP: con 3A07, lp=1, jmp_taken=1 → T1.
  - 14 OUT → O1 (3F06) → T1.
  - 15 HLT → HALT: con 3E07, halted=1. HALT holds until CLR.
  - Any other value, including opcodes 10–13 and values >15: set bad_op and go to T1. The instruction executes as a 3-state NOP.
- Execution states take tstate values 4, 5, 6 in sequence. HALT reports tstate 4.
- Advance condition:
  - RUN=1: advance every falling edge.
  - RUN=0: advance only on a falling edge where STEP=1 and the registered previous STEP value is 0. The edge detector updates every falling edge.
  - Otherwise the state holds and con is stable.
- RUN may change at any time; the new value takes effect at the next falling edge.
- bad_op clears only on CLR.

## Timing
- CLR=1 at a falling edge sets state S0, bad_op=0 and the STEP history register to 0. Outputs after reset:
  - con=3E07, lp=0, tstate=0, fetch=0, halted=0, bad_op=0, jmp_taken=0.
- CLR has priority over RUN, STEP and HALT. CLR mid-instruction abandons the instruction, with no partial-state hold.
- Outputs change only after falling edges, so con is stable around each rising edge where the datapath acts.
- Instruction length in free-run, counting T1 through the return to T1:
  - LDA 5, ADD/SUB/AND/OR 6, SWAP 6, OUT 4.
  - JMP 4. Conditional branch: 4 if taken, 3 if not.
  - Illegal opcode 3.
- First T1 occurs one falling edge after CLR deasserts (from S0).
- opcode and flags are used only in the T3→next decision. Changes at any other time have no effect.
- STEP held high produces one advance. STEP asserted while CLR=1 produces no advance and is not remembered.

## Test plan
- Reset, then free-run with opcode=0: con sequence 3E07, 5E07, BE07, 2607, 1A07, 2C07, 5E07. tstate 0,1,2,3,4,5,1.
- opcode=7 (JZ) with ZF=1: after T3, con=3A07, lp=1, jmp_taken=1 for 1 cycle, then T1. Repeat with ZF=0: T3 goes directly to T1 and lp stays 0.
- opcode=11: bad_op rises after T3 and the next state is T1. Then opcode=1 (ADD): bad_op stays 1 and A3 con=3C0F. CLR clears bad_op.
- opcode=15: halted=1 and con=3E07 for 20 cycles with any opcode/RUN/STEP. CLR returns to S0.
- RUN=0 with STEP held high for 10 cycles: exactly one state advance. 3 separate STEP pulses: 3 advances. CLR asserted during a pulse: state S0, no advance.
- CLR asserted during SUB state A2: the next state is S0 with con=3E07. Then the full SUB sequence completes with A3 con=3C1F.
